// File: rtl/truth_table_probe_pkg.sv
// Shared definitions for the truth-table probe:
//   - state encoding of the run FSM
//   - 3-bit function codes reported on func
//   - golden 4-bit tables; bit i is the gate output for input vector i = {a,b}
package tt_probe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F_UNKNOWN = 3'd0;
    localparam logic [2:0] F_AND     = 3'd1;
    localparam logic [2:0] F_ANDN    = 3'd2;
    localparam logic [2:0] F_OR      = 3'd3;
    localparam logic [2:0] F_XOR     = 3'd4;
    localparam logic [2:0] F_NAND    = 3'd5;
    localparam logic [2:0] F_NOR     = 3'd6;
    localparam logic [2:0] F_XNOR    = 3'd7;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_ANDN = 4'b0010;  // ~a & b
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/truth_table_probe_if.sv
// Signal bundle between the probe and whoever starts it / hosts the gate.
//   start  : run request            (master -> slave)
//   dut_s  : gate output under test (master -> slave)
//   x, y   : gate inputs a, b       (slave -> master)
//   busy   : vectors being applied  (slave -> master)
//   done   : run complete, level    (slave -> master)
//   tt     : captured truth table   (slave -> master)
//   func   : classification of tt   (slave -> master)
interface truth_table_probe_if;
    logic       start;
    logic       dut_s;
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic [3:0] tt;
    logic [2:0] func;

    modport master (
        output start, dut_s,
        input  x, y, busy, done, tt, func
    );

    modport slave (
        input  start, dut_s,
        output x, y, busy, done, tt, func
    );
endinterface

// File: rtl/truth_table_probe_classify.sv
// tt_classify: combinational lookup from a 4-bit truth table to a function
// code. Anything not in the table (constants, single-input functions, ...)
// reports F_UNKNOWN.
//   tt   in  4  truth table, bit i = output for vector i = {a,b}
//   func out 3  function code
module tt_classify
    import tt_probe_pkg::*;
(
    input  logic [3:0] tt,
    output logic [2:0] func
);

    always_comb begin
        func = F_UNKNOWN;
        case (tt)
            TT_AND:  func = F_AND;
            TT_ANDN: func = F_ANDN;
            TT_OR:   func = F_OR;
            TT_XOR:  func = F_XOR;
            TT_NAND: func = F_NAND;
            TT_NOR:  func = F_NOR;
            TT_XNOR: func = F_XNOR;
            default: func = F_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/truth_table_probe.sv
// truth_table_probe: on start, walks {x,y} through 00,01,10,11, holds each
// vector SETTLE cycles, samples dut_s at the end of each hold into tt[vi],
// then reports the table and its classification with a level done.
//   SETTLE  hold cycles per vector, 1..15
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   bus     slave side of truth_table_probe_if (start, dut_s in;
//           x, y, busy, done, tt, func out)
module truth_table_probe
    import tt_probe_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input logic                 clk,
    input logic                 rst,
    truth_table_probe_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [1:0] vi;       // index of the vector currently on x/y
    logic [3:0] sc;       // cycles the current vector has been held
    logic [1:0] vec;      // {x,y}
    logic       busy;
    logic       done;
    logic [3:0] tt;
    logic [2:0] func;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            vi    <= 2'd0;
            sc    <= 4'd0;
            vec   <= 2'b00;
            busy  <= 1'b0;
            done  <= 1'b0;
            tt    <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Restart from DONE is immediate; the old table is dropped.
                    if (bus.start) begin
                        state <= ST_RUN;
                        vi    <= 2'd0;
                        sc    <= 4'd0;
                        vec   <= 2'b00;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        tt    <= 4'b0000;
                    end
                end
                ST_RUN: begin
                    // start is deliberately not looked at here.
                    if (sc == SETTLE_LAST) begin
                        tt[vi] <= bus.dut_s;
                        sc     <= 4'd0;
                        if (vi != 2'd3) begin
                            vi  <= vi + 2'd1;
                            vec <= vi + 2'd1;
                        end else begin
                            state <= ST_DONE;
                            vec   <= 2'b00;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    tt_classify u_classify (
        .tt   (tt),
        .func (func)
    );

    assign bus.x    = vec[1];
    assign bus.y    = vec[0];
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.tt   = tt;
    assign bus.func = func;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe. Three probes with SETTLE = 1, 2, 3
// each drive a behavioural gate model; isel picks which probe is observed.
module tb_truth_table_probe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic st  = 1'b0;
    int   isel = 0;
    int   m0 = 0, m1 = 1, m2 = 3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    truth_table_probe_if if0 ();
    truth_table_probe_if if1 ();
    truth_table_probe_if if2 ();

    // gate models: 0 AND, 1 ANDN(~a&b), 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR,
    // 7 const 0, 8 const 1, 9 passes a
    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0: return a & b;
            1: return ~a & b;
            2: return a | b;
            3: return a ^ b;
            4: return ~(a & b);
            5: return ~(a | b);
            6: return ~(a ^ b);
            7: return 1'b0;
            8: return 1'b1;
            default: return a;
        endcase
    endfunction

    // probe 1 sees its gate through one register of delay
    logic g1_q = 1'b0;
    always @(posedge clk) g1_q <= gate(m1, if1.x, if1.y);

    assign if0.start = st && (isel == 0);
    assign if1.start = st && (isel == 1);
    assign if2.start = st && (isel == 2);
    assign if0.dut_s = gate(m0, if0.x, if0.y);
    assign if1.dut_s = g1_q;
    assign if2.dut_s = gate(m2, if2.x, if2.y);

    truth_table_probe #(.SETTLE(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    truth_table_probe #(.SETTLE(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    truth_table_probe #(.SETTLE(3)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [1:0] oxy;
    logic       obusy, odone;
    logic [3:0] ott;
    logic [2:0] ofunc;
    always_comb begin
        oxy = 2'b00; obusy = 1'b0; odone = 1'b0; ott = 4'h0; ofunc = 3'd0;
        case (isel)
            0: begin oxy = {if0.x, if0.y}; obusy = if0.busy; odone = if0.done; ott = if0.tt; ofunc = if0.func; end
            1: begin oxy = {if1.x, if1.y}; obusy = if1.busy; odone = if1.done; ott = if1.tt; ofunc = if1.func; end
            default: begin oxy = {if2.x, if2.y}; obusy = if2.busy; odone = if2.done; ott = if2.tt; ofunc = if2.func; end
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_xy"},   8'(oxy),   8'h0);
        chk({tag, "_busy"}, 8'(obusy), 8'h0);
        chk({tag, "_done"}, 8'(odone), 8'h0);
        chk({tag, "_tt"},   8'(ott),   8'h0);
        chk({tag, "_func"}, 8'(ofunc), 8'h0);
    endtask

    // one start pulse, then cycle-by-cycle check of x/y, busy, done
    task automatic run(input string tag, input int settle,
                       input logic [3:0] ett, input logic [2:0] ef);
        st = 1'b1;
        step();                       // accepting edge E0
        st = 1'b0;
        chk({tag, "_e0_busy"}, 8'(obusy), 8'h1);
        chk({tag, "_e0_done"}, 8'(odone), 8'h0);
        chk({tag, "_e0_xy"},   8'(oxy),   8'h0);
        chk({tag, "_e0_tt"},   8'(ott),   8'h0);
        for (int k = 1; k <= 4 * settle; k++) begin
            step();
            chk({tag, "_xy"},   8'(oxy),   (k < 4 * settle) ? 8'(k / settle) : 8'h0);
            chk({tag, "_busy"}, 8'(obusy), (k < 4 * settle) ? 8'h1 : 8'h0);
            chk({tag, "_done"}, 8'(odone), (k == 4 * settle) ? 8'h1 : 8'h0);
        end
        chk({tag, "_tt"},   8'(ott),   8'(ett));
        chk({tag, "_func"}, 8'(ofunc), 8'(ef));
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        isel = 0; chk_reset("rst0");
        isel = 1; chk_reset("rst1");
        isel = 2; chk_reset("rst2");

        // SETTLE=1 gate sweep
        isel = 0;
        m0 = 0; run("and",   1, 4'b1000, 3'd1);
        m0 = 1; run("andn",  1, 4'b0010, 3'd2);
        m0 = 2; run("or",    1, 4'b1110, 3'd3);
        m0 = 4; run("nand",  1, 4'b0111, 3'd5);
        m0 = 5; run("nor",   1, 4'b0001, 3'd6);
        m0 = 6; run("xnor",  1, 4'b1001, 3'd7);
        m0 = 7; run("zero",  1, 4'b0000, 3'd0);
        m0 = 8; run("one",   1, 4'b1111, 3'd0);
        m0 = 9; run("pass_a",1, 4'b1100, 3'd0);

        // SETTLE=2 with a registered (one-cycle) ANDN gate
        isel = 1; m1 = 1;
        run("andn_dly", 2, 4'b0010, 3'd2);

        // SETTLE=3 XOR
        isel = 2; m2 = 3;
        run("xor_s3", 3, 4'b0110, 3'd4);

        // reset two cycles into a run; const-1 gate makes the partial table nonzero
        isel = 0; m0 = 8;
        st = 1'b1; step(); st = 1'b0;   // E0
        step(); step();                  // E0+2: tt = 0011
        chk("mid_tt_partial", 8'(ott), 8'h3);
        rst = 1'b1; step(); rst = 1'b0;
        chk_reset("abort");
        m0 = 0; run("and_after_abort", 1, 4'b1000, 3'd1);

        // start pulsed during RUN is ignored
        m0 = 3;
        st = 1'b1; step(); st = 1'b0;   // E0
        step();                          // E0+1
        st = 1'b1; step(); st = 1'b0;   // E0+2
        chk("ign_xy2",   8'(oxy),   8'h2);
        chk("ign_busy2", 8'(obusy), 8'h1);
        step();                          // E0+3
        chk("ign_xy3",   8'(oxy),   8'h3);
        chk("ign_done3", 8'(odone), 8'h0);
        step();                          // E0+4
        chk("ign_done4", 8'(odone), 8'h1);
        chk("ign_tt",    8'(ott),   8'h6);
        chk("ign_func",  8'(ofunc), 8'h4);

        // start held high: done one cycle in every five, tt valid then
        m0 = 0;
        st = 1'b1;
        step();                          // k = 0 accepted from DONE
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("held_done", 8'(odone), (k % 5 == 4) ? 8'h1 : 8'h0);
            chk("held_busy", 8'(obusy), (k % 5 == 4) ? 8'h0 : 8'h1);
            if (k % 5 == 4) begin
                chk("held_tt",   8'(ott),   8'h8);
                chk("held_func", 8'(ofunc), 8'h1);
            end
        end
        st = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

Sequential stimulus-and-capture engine for 2-input combinational gates. On `start` it drives the four input vectors 00, 01, 10, 11 onto `x`/`y`, samples the gate output `dut_s` once per vector, and assembles a 4-bit truth table. It then classifies the table into a function code. It is the hardware counterpart of the team's gate exercise benches: the gate modules are the device under test, and this block drives them and reads their responses.

## Interface
- `SETTLE`, default 1: cycles each vector is held before `dut_s` is sampled; legal range 1..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `dut_s`  in  1  gate output under test.
- `x`  out  1  gate input a, registered.
- `y`  out  1  gate input b, registered.
- `busy`  out  1  high while vectors are being applied.
- `done`  out  1  level; high from run completion until the next accepted start or reset.
- `tt`  out  4  captured table: `tt[i]` = `dut_s` for vector i = {x,y}.
- `func`  out  3  classification of `tt`; valid when `done`=1.

## Operation
- States:
  - IDLE.
  - RUN, with a 2-bit vector index `vi` and a 4-bit settle counter `sc`.
  - DONE.
- IDLE or DONE with `start`=1 at edge E0 moves to RUN at E0:
  - `vi`=0, `sc`=0, {x,y}=00.
  - `busy`=1, `done`=0, `tt`=0000.
- In RUN, `sc` increments every cycle. When `sc`=SETTLE-1, the next edge:
  - samples `dut_s` into `tt[vi]`;
  - resets `sc` to 0;
  - if `vi`<3: increments `vi` and drives {x,y}=`vi`+1;
  - if `vi`=3: moves to DONE with `busy`=0, `done`=1, {x,y}=00.
- `start` during RUN is ignored; there is no queueing.
- `start` in DONE restarts immediately. `done` drops at the accepting edge and `tt` clears.
- `func` is derived combinationally from `tt`:
  - 0 = unknown;
  - 1 = AND (1000);
  - 2 = ANDN, ~a&b (0010);
  - 3 = OR (1110);
  - 4 = XOR (0110);
  - 5 = NAND (0111);
  - 6 = NOR (0001);
  - 7 = XNOR (1001).
- Any other pattern gives 0, including constants 0000 and 1111 and the single-input functions.
- `tt` fills progressively during RUN. Consumers read it only when `done`=1.

## Timing
- Reset values: `x`=0, `y`=0, `busy`=0, `done`=0, `tt`=0000, `func`=0, state IDLE.
- Reset dominates `start` in the same cycle.
- Reset mid-run aborts the run. All outputs return to reset values at that edge, and nothing partial is retained.
- Vector i is valid on `x`/`y` from edge E0+i·SETTLE.
- `dut_s` for vector i is sampled at edge E0+(i+1)·SETTLE. The gate therefore has SETTLE full cycles of propagation.
- `done` rises at edge E0+4·SETTLE, e.g. 4 cycles for SETTLE=1 and 12 cycles for SETTLE=3.
- `busy` is high for exactly 4·SETTLE cycles per run.
- With `start` held high continuously:
  - runs repeat back to back;
  - `done` is high for exactly one cycle between runs;
  - `tt`/`func` are valid in that cycle.
- `dut_s` is assumed combinationally driven from `x`/`y` within the settle window. No synchronizer is included.

## Structure
- Package `tt_probe_pkg`:
  - state enum {IDLE, RUN, DONE};
  - 3-bit `func` code constants;
  - 4-bit golden table constants (TT_AND=4'b1000, TT_ANDN=4'b0010, and so on).
- Sub-module `tt_classify`: purely combinational `tt` to `func` lookup. It is reused by benches as the reference model.
- Top module holds the FSM, counters and output registers.

## Test plan
- AND model on `dut_s`, SETTLE=1, single `start` pulse -> `done` 4 cycles after the accepting edge, `tt`=1000, `func`=1, {x,y} sequence 00,01,10,11,00.
- ANDN (~a&b) model -> `tt`=0010, `func`=2. Same model with one cycle of gate delay and SETTLE=2 -> still 0010, `done` at E0+8.
- XOR model, SETTLE=3 -> `busy` high 12 cycles, `done` at E0+12, `tt`=0110, `func`=4.
- `dut_s` tied 0 -> `tt`=0000, `func`=0. `dut_s` tied 1 -> `tt`=1111, `func`=0.
- `rst` asserted 2 cycles into a run -> next edge: `busy`=0, `done`=0, `tt`=0000, x=y=0. A following `start` completes a normal AND run.
- `start` pulsed during RUN -> ignored, `done` still at E0+4. `start` held high -> `done` high one cycle every 5 cycles (SETTLE=1), `tt` correct each time.
